audiodac_feeder: RTL

Host-side sequencer that moves 16-bit samples from a valid/ready sample stream into the audiodac FIFO through its rdy/ack handshake. Writes are bursty: when the FIFO reports empty, it writes until the FIFO reports full or MAX_BURST words have been written, then waits for empty again. It also stages the mode/volume/OSR configuration and applies it only at burst boundaries. Underrun and handshake-timeout conditions are reported for the host ISR.

---
 rtl/audiodac_feeder_pkg.sv | 24 ++
 rtl/audiodac_sat_cnt.sv | 34 +++
 rtl/audiodac_feeder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/audiodac_feeder_pkg.sv
// Shared widths, state encoding and config bundle for the audiodac feeder.
package audiodac_feeder_pkg;

    localparam int SAMPLE_W = 16;
    localparam int VOL_W    = 4;
    localparam int OSR_W    = 2;
    localparam int STATE_W  = 3;
    localparam int BURST_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_EMPTY = 3'd1,
        ST_FETCH      = 3'd2,
        ST_REQ        = 3'd3,
        ST_RELEASE    = 3'd4
    } state_e;

    typedef struct packed {
        logic             mode;
        logic [VOL_W-1:0] volume;
        logic [OSR_W-1:0] osr;
    } cfg_t;

endpackage

// File: rtl/audiodac_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module audiodac_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/audiodac_feeder.sv
// Bursty sample feeder into the audiodac FIFO rdy/ack handshake, with
// config staging applied at burst boundaries and underrun/timeout reporting.
module audiodac_feeder
    import audiodac_feeder_pkg::*;
#(
    parameter int               MAX_BURST   = 32,
    parameter int               ACK_TIMEOUT = 64,
    parameter logic [VOL_W-1:0] RST_VOLUME  = 4'd0,
    parameter logic [OSR_W-1:0] RST_OSR     = 2'd0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [SAMPLE_W-1:0] s_data_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    output logic [SAMPLE_W-1:0] fifo_o,
    output logic                fifo_rdy_o,
    input  logic                fifo_ack_i,
    input  logic                fifo_full_i,
    input  logic                fifo_empty_i,
    input  logic                cfg_mode_i,
    input  logic [VOL_W-1:0]    cfg_volume_i,
    input  logic [OSR_W-1:0]    cfg_osr_i,
    input  logic                cfg_wr_i,
    output logic                mode_o,
    output logic [VOL_W-1:0]    volume_o,
    output logic [OSR_W-1:0]    osr_o,
    output logic                cfg_pending_o,
    output logic                busy_o,
    output logic                timeout_o,
    output logic [15:0]         underrun_cnt_o,
    input  logic                cnt_clr_i
);

    localparam int   WAIT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam cfg_t RST_CFG   = '{mode: 1'b0, volume: RST_VOLUME, osr: RST_OSR};

    state_e                state_q, state_d;
    logic [SAMPLE_W-1:0]   fifo_q, fifo_d;
    logic                  rdy_q, rdy_d;
    logic [BURST_W-1:0]    burst_q, burst_d;
    cfg_t                  cfg_app_q, cfg_app_d;
    cfg_t                  shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic                  busy_q, busy_d;
    logic                  timeout_q, timeout_d;
    logic                  und_cond_q;

    logic                  apply;
    logic                  timeout_set;
    logic                  xfer;
    logic                  und_cond;
    logic                  und_evt;
    logic                  in_req;
    logic                  ack_expired;
    logic [WAIT_W-1:0]     wait_cnt;

    assign s_ready_o = (state_q == ST_FETCH) && !fifo_full_i && en_i;
    assign xfer      = s_valid_i && s_ready_o;
    assign in_req    = (state_q == ST_REQ);

    // Wait counter is cleared outside REQ, so it reads k during the k-th cycle after entry
    // and expiry fires on the edge ACK_TIMEOUT cycles after fifo_rdy_o rose.
    assign ack_expired = in_req && (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1));

    assign und_cond = (state_q == ST_FETCH) && fifo_empty_i && !s_valid_i;
    assign und_evt  = und_cond && !und_cond_q;

    always_comb begin
        state_d     = state_q;
        fifo_d      = fifo_q;
        rdy_d       = rdy_q;
        burst_d     = burst_q;
        apply       = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                apply = 1'b1;
                if (en_i) state_d = ST_WAIT_EMPTY;
            end
            ST_WAIT_EMPTY: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (fifo_empty_i) begin
                    state_d = ST_FETCH;
                    burst_d = '0;
                    apply   = 1'b1;
                end
            end
            ST_FETCH: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (fifo_full_i) begin
                    state_d = ST_WAIT_EMPTY;
                end else if (xfer) begin
                    fifo_d  = s_data_i;
                    rdy_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (fifo_ack_i) begin
                    rdy_d   = 1'b0;
                    burst_d = burst_q + 1'b1;
                    state_d = ST_RELEASE;
                end else if (ack_expired) begin
                    rdy_d       = 1'b0;
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (!fifo_ack_i) begin
                    if (!en_i) begin
                        state_d = ST_IDLE;
                    end else if (fifo_full_i || (burst_q == BURST_W'(MAX_BURST))) begin
                        state_d = ST_WAIT_EMPTY;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b0;
            end
        endcase
    end

    // A write in the apply cycle lands in the shadow while the old shadow goes live.
    always_comb begin
        shadow_d  = shadow_q;
        cfg_app_d = cfg_app_q;
        pending_d = pending_q;
        if (apply && pending_q) begin
            cfg_app_d = shadow_q;
            pending_d = 1'b0;
        end
        if (cfg_wr_i) begin
            shadow_d  = '{mode: cfg_mode_i, volume: cfg_volume_i, osr: cfg_osr_i};
            pending_d = 1'b1;
        end
    end

    always_comb begin
        timeout_d = timeout_q;
        if (cnt_clr_i) begin
            timeout_d = 1'b0;
        end else if (timeout_set) begin
            timeout_d = 1'b1;
        end
        busy_d = (state_d == ST_FETCH) || (state_d == ST_REQ) || (state_d == ST_RELEASE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            fifo_q     <= '0;
            rdy_q      <= 1'b0;
            burst_q    <= '0;
            cfg_app_q  <= RST_CFG;
            shadow_q   <= RST_CFG;
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            und_cond_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fifo_q     <= fifo_d;
            rdy_q      <= rdy_d;
            burst_q    <= burst_d;
            cfg_app_q  <= cfg_app_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            und_cond_q <= und_cond;
        end
    end

    audiodac_sat_cnt #(.WIDTH(16)) u_underrun (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (und_evt),
        .clr_i (cnt_clr_i),
        .cnt_o (underrun_cnt_o)
    );

    audiodac_sat_cnt #(.WIDTH(WAIT_W)) u_ack_wait (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (in_req),
        .clr_i (!in_req),
        .cnt_o (wait_cnt)
    );

    assign fifo_o        = fifo_q;
    assign fifo_rdy_o    = rdy_q;
    assign mode_o        = cfg_app_q.mode;
    assign volume_o      = cfg_app_q.volume;
    assign osr_o         = cfg_app_q.osr;
    assign cfg_pending_o = pending_q;
    assign busy_o        = busy_q;
    assign timeout_o     = timeout_q;

endmodule
